dff_pipe_bank: RTL and testbench
================================

// Module: dff_pipe_bank
// PURPOSE
//  Parametrised elastic register pipeline. Scan-insertion fixture with many
//  async-reset flops, enable-gated flops and a saturating counter.
//  Carries WIDTH-bit data plus an OR-reduce flag through DEPTH stages under
//  valid/ready flow control.
//  Sits between a test source and sink as a DUT for scan-chain and
//  state-capture flows. Must behave identically before and after flop
//  replacement.
// PARAMETERS
//  WIDTH  8   data width per stage, >=1
//  DEPTH  3   number of pipeline stages, >=1
//  CNT_W  16  width of the completed-transfer counter, >=1
// PORTS
//  clk        in   1        clock, all flops rising-edge
//  rst        in   1        reset, asynchronous, active-high
//  clear      in   1        synchronous flush of pipeline and counter
//  in_valid   in   1        upstream data valid
//  in_ready   out  1        pipeline can accept in_data this cycle
//  in_data    in   WIDTH    upstream data
//  out_valid  out  1        last stage holds valid data
//  out_ready  in   1        downstream accepts out_data this cycle
//  out_data   out  WIDTH    last-stage data
//  out_flag   out  1        |data as captured at stage 0, travels with data
//  count      out  CNT_W    number of output transfers, saturating
// BEHAVIOUR
//  Reset (rst=1, async)
//   - All stage valid, data and flag flops = 0; count = 0.
//   - Hence out_valid=0, out_data=0, out_flag=0, in_ready=1 (unless clear=1).
//   - Reset asserted mid-transfer discards all in-flight data immediately.
//  Stage model
//   - Stage k (0..DEPTH-1) holds v[k], d[k], f[k]. Stage DEPTH-1 drives outputs.
//   - adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
//   - adv[k] = !v[k] | adv[k+1] (ready ripples combinationally; bubbles collapse).
//   - in_ready = adv[0] & !clear.
//  Data movement
//   - Stage k loads stage k-1 when adv[k]=1; stage 0 loads the input.
//   - v[0] <= in_valid & in_ready, d[0] <= in_data, f[0] <= |in_data.
//   - d/f load only when adv[k]=1 and the source is valid. Otherwise they hold
//     (enable flops). v[k] always updates when adv[k]=1.
//  Latency and throughput
//   - Accepted word appears on out_valid exactly DEPTH cycles later if never
//     stalled.
//   - Sustained throughput is 1 word/cycle with out_ready=1.
//   - No combinational path in_data->out_data. out_ready->in_ready is
//     combinational.
//   - Stall: out_valid=1 & out_ready=0 holds out_data/out_flag stable.
//     Upstream stages still fill bubbles. in_ready=0 only when all DEPTH
//     stages are valid.
//  Counter
//   - count increments by 1 on each cycle with out_valid & out_ready.
//   - Saturates at 2^CNT_W-1 and never wraps.
//  Clear (sync)
//   - On a clk edge with clear=1: all v[k]=0, d[k]=0, f[k]=0, count=0.
//   - An in_valid presented that cycle is NOT accepted (in_ready=0).
//   - An out_valid&out_ready handshake in that cycle still counts as consumed
//     by the sink, but count ends at 0.
//   - clear takes priority over every other update.
//  Simultaneous events
//   - Full pipeline with out_ready=1 and in_valid=1: output, shift and accept
//     all happen in the same cycle; occupancy stays DEPTH.
// TESTING
//  1 Reset: rst pulse with in_valid=1, in_data=8'hFF
//    -> out_valid=0, out_data=0, out_flag=0, count=0, in_ready=1 during/after.
//  2 Latency: DEPTH=3, out_ready=1, single word 8'hA5 at cycle 0
//    -> out_valid=1, out_data=8'hA5, out_flag=1 at cycle 3 only; count=1.
//  3 Flag: stream 8'h00, 8'h01, 8'h80 with out_ready=1
//    -> out_flag sequence 0,1,1 aligned with data; count=3.
//  4 Backpressure: out_ready=0, send 5 words 1..5
//    -> 3 accepted, in_ready=0 after 3rd. Then out_ready=1 yields 1..5 in
//       order, no loss or duplicates.
//  5 Clear mid-stream: 2 words in flight, clear=1 with in_valid=1 8'h33
//    -> next cycle out_valid=0, count=0, 8'h33 never emitted.
//  6 Saturation: CNT_W=2, 5 transfers -> count 1,2,3,3,3.

Source files
------------

// File: rtl/dff_pipe_bank.sv
// Elastic register pipeline: carries WIDTH-bit data plus an OR-reduce flag
// through DEPTH stages under valid/ready flow control, and counts completed
// output transfers in a saturating counter. Intended as a scan/state-capture
// fixture, so every state element is a plain async-reset flop, optionally
// enable-gated.
//
// Ports:
//   clk        clock, all flops rising-edge
//   rst        asynchronous, active-high reset
//   clear      synchronous flush of pipeline and counter (highest priority)
//   in_valid   upstream data valid
//   in_ready   pipeline can accept in_data this cycle
//   in_data    upstream data
//   out_valid  last stage holds valid data
//   out_ready  downstream accepts out_data this cycle
//   out_data   last-stage data
//   out_flag   |data as captured at stage 0, travels with the data
//   count      number of output transfers, saturating at all-ones
module dff_pipe_bank #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_flag,
  output logic [CNT_W-1:0] count
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] flag_q, flag_d;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0] adv;
  logic             hole;
  logic             out_hs;

  // adv[k] is true when stage k can take new contents this cycle: the sink
  // is ready, or some stage at or downstream of k is empty (bubble collapse).
  // Computed as a downstream scan rather than adv[k+1] to keep the vector
  // free of self-dependence.
  always_comb begin
    hole = 1'b0;
    adv  = '0;
    for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
      hole   = hole | ~valid_q[k];
      adv[k] = hole | out_ready;
    end
  end

  assign in_ready  = adv[0] & ~clear;
  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_flag  = flag_q[DEPTH-1];
  assign count     = cnt_q;
  assign out_hs    = out_valid & out_ready;

  always_comb begin
    valid_d = valid_q;
    flag_d  = flag_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (clear) begin
      valid_d = '0;
      flag_d  = '0;
      cnt_d   = '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_d[k] = '0;
      end
    end else begin
      // Stage 0 takes the input; payload flops only load on a real word.
      if (adv[0]) begin
        valid_d[0] = in_valid & in_ready;
        if (in_valid) begin
          data_d[0] = in_data;
          flag_d[0] = |in_data;
        end
      end
      for (int k = 1; k < int'(DEPTH); k++) begin
        if (adv[k]) begin
          valid_d[k] = valid_q[k-1];
          if (valid_q[k-1]) begin
            data_d[k] = data_q[k-1];
            flag_d[k] = flag_q[k-1];
          end
        end
      end
      if (out_hs && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      flag_q  <= '0;
      cnt_q   <= '0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      flag_q  <= flag_d;
      cnt_q   <= cnt_d;
      for (int k = 0; k < int'(DEPTH); k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

endmodule

// File: tb/tb_dff_pipe_bank.sv
// Self-checking bench for dff_pipe_bank (WIDTH=8, DEPTH=3). A second
// instance with CNT_W=2 shares all inputs and is used for counter saturation.
module tb_dff_pipe_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_flag;
  logic [15:0] count;

  logic       sat_in_ready;
  logic       sat_out_valid;
  logic [7:0] sat_out_data;
  logic       sat_out_flag;
  logic [1:0] sat_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0]  sb[$];       // {flag, data} expected at the output
  logic [15:0] cnt_m = '0;  // reference transfer count
  bit          last_hs;

  always #5 clk = ~clk;

  dff_pipe_bank #(.WIDTH(8), .DEPTH(3), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flag(out_flag), .count(count)
  );

  dff_pipe_bank #(.WIDTH(8), .DEPTH(3), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
    .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
    .out_flag(sat_out_flag), .count(sat_count)
  );

  // One clock cycle: record handshakes seen with the current inputs, update
  // the scoreboard and count model, then return at the following negedge.
  task automatic tick();
    logic [8:0] exp;
    bit acc, hs;
    #1;
    acc = in_valid && in_ready;
    hs  = out_valid && out_ready;
    last_hs = hs;
    if (hs) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_output: got %h, expected no output", out_data);
      end else begin
        exp = sb.pop_front();
        if ({out_flag, out_data} !== exp) begin
          n_fail++;
          $display("FAIL sb_output: got flag/data %b/%h, expected %b/%h",
                   out_flag, out_data, exp[8], exp[7:0]);
        end
      end
    end
    if (clear) begin
      sb.delete();
      cnt_m = '0;
    end else begin
      if (acc) sb.push_back({|in_data, in_data});
      if (hs && cnt_m != 16'hFFFF) cnt_m = cnt_m + 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    sb.delete();
    cnt_m = '0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
    n_tests++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 00", out_data); end
    n_tests++;
    if (out_flag !== 1'b0) begin n_fail++; $display("FAIL reset_out_flag: got %b, expected 0", out_flag); end
    n_tests++;
    if (count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d, expected 0", count); end
    n_tests++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 16'd0) begin
      n_fail++;
      $display("FAIL post_reset: got valid/ready/count %b/%b/%0d, expected 0/1/0",
               out_valid, in_ready, count);
    end
  endtask

  task automatic test_latency();
    idle_inputs();
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      n_tests++;
      if (out_valid !== (i == 3)) begin
        n_fail++;
        $display("FAIL latency_valid_c%0d: got %b, expected %b", i, out_valid, (i == 3));
      end
      if (i == 3) begin
        n_tests++;
        if (out_data !== 8'hA5 || out_flag !== 1'b1) begin
          n_fail++;
          $display("FAIL latency_payload: got %h/%b, expected a5/1", out_data, out_flag);
        end
      end
      tick();
    end
    n_tests++;
    if (count !== 16'd1) begin n_fail++; $display("FAIL latency_count: got %0d, expected 1", count); end
  endtask

  task automatic test_flag();
    logic [7:0] words [3];
    logic [15:0] c0;
    words[0] = 8'h00; words[1] = 8'h01; words[2] = 8'h80;
    c0 = cnt_m;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = words[i];
      tick();
    end
    in_valid = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (count !== c0 + 16'd3) begin
      n_fail++;
      $display("FAIL flag_count: got %0d, expected %0d", count, c0 + 16'd3);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int cyc  = 0;
    idle_inputs();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; in_data = 8'(sent + 1);
      #1;
      n_tests++;
      if (in_ready !== (sent < 3)) begin
        n_fail++;
        $display("FAIL bp_in_ready_c%0d: got %b, expected %b", c, in_ready, (sent < 3));
      end
      if (out_valid) begin
        n_tests++;
        if ({out_flag, out_data} !== sb[0]) begin
          n_fail++;
          $display("FAIL bp_stall_hold: got %h, expected %h", out_data, sb[0][7:0]);
        end
      end
      if (in_ready) sent++;
      tick();
    end
    out_ready = 1'b1;
    while (sent < 5 && cyc < 20) begin
      in_valid = 1'b1; in_data = 8'(sent + 1);
      #1;
      if (in_ready) sent++;
      tick();
      cyc++;
    end
    n_tests++;
    if (sent != 5) begin n_fail++; $display("FAIL bp_accept_timeout: got %0d words, expected 5", sent); end
    in_valid = 1'b0;
    repeat (5) tick();
    n_tests++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL bp_drain: got %0d left, expected 0", sb.size()); end
  endtask

  task automatic test_clear();
    idle_inputs();
    in_valid = 1'b1; in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; clear = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL clear_in_ready: got %b, expected 0", in_ready); end
    tick();
    clear = 1'b0; in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0 || count !== 16'd0) begin
      n_fail++;
      $display("FAIL clear_state: got valid/count %b/%0d, expected 0/0", out_valid, count);
    end
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL clear_no_emit_c%0d: got valid %b data %h, expected valid 0", i, out_valid, out_data);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_data = 8'(i * 17 + 3);
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready_c%0d: got %b, expected 1", i, in_ready); end
      tick();
      if (i >= 2) begin
        n_tests++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_out_valid_c%0d: got %b, expected 1", i, out_valid); end
      end
    end
    in_valid = 1'b0;
    repeat (4) tick();
    n_tests++;
    if (count !== cnt_m) begin n_fail++; $display("FAIL b2b_count: got %0d, expected %0d", count, cnt_m); end
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h40 + i);
      tick();
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: got valid/data/ready %b/%h/%b, expected 0/00/1",
               out_valid, out_data, in_ready);
    end
    sb.delete();
    cnt_m = '0;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5];
    int k = 0;
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3;
    exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_valid = (i < 5); in_data = 8'(i + 1);
      tick();
      if (last_hs && k < 5) begin
        n_tests++;
        if (sat_count !== exp_sat[k]) begin
          n_fail++;
          $display("FAIL sat_count_%0d: got %0d, expected %0d", k, sat_count, exp_sat[k]);
        end
        k++;
      end
    end
    n_tests++;
    if (k != 5) begin n_fail++; $display("FAIL sat_transfers: got %0d, expected 5", k); end
    n_tests++;
    if (count !== 16'd5) begin n_fail++; $display("FAIL sat_wide_count: got %0d, expected 5", count); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_flag();
    test_backpressure();
    test_clear();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
